// File: rtl/load_store_unit_if.sv
// Request/response handshake between the MEM stage and the LSU, plus the LSU's word-wide memory port.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_read;
    logic        mem_write;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_read, mem_write
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_read, mem_write
    );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store controller: word-aligns addresses, extends sub-word loads and
// performs read-modify-write for sub-word stores against a word-addressed memory.
//
// state | meaning
// IDLE  | ready for a request
// RD    | mem_read asserted; load data or RMW word captured at the end
// SETUP | mem_wdata settled, one cycle ahead of the write strobe
// WR    | mem_write asserted for exactly this cycle
// RESP  | resp_valid pulse, then back to IDLE
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    load_store_unit_if.slave   bus
);
    typedef enum logic [2:0] {S_IDLE, S_RD, S_SETUP, S_WR, S_RESP} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        req_bad;

    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] sz,
                                                input logic sgn, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (sz)
            SZ_BYTE: return {{24{sgn & b[7]}}, b};
            SZ_HALF: return {{16{sgn & h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] wd,
                                                input logic [1:0] sz, input logic [1:0] lane);
        logic [31:0] r;
        r = w;
        if (sz == SZ_BYTE) begin
            r[{lane, 3'b000} +: 8] = wd[7:0];
        end else if (lane[1]) begin
            r[31:16] = wd[15:0];
        end else begin
            r[15:0] = wd[15:0];
        end
        return r;
    endfunction

    always_comb begin
        req_bad = (bus.req_size == 2'b11)
               || (bus.req_size == SZ_HALF && bus.req_addr[0])
               || (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)
               || ({1'b0, bus.req_addr} >= ADDR_LIMIT);
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        size_d       = size_q;
        signed_d     = signed_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;
        // Memory-side strobes are registered: each is set on the edge that enters its state.
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    write_d    = bus.req_write;
                    size_d     = bus.req_size;
                    signed_d   = bus.req_signed;
                    lane_d     = bus.req_addr[1:0];
                    wdata_d    = bus.req_wdata;
                    mem_addr_d = {bus.req_addr[31:2], 2'b00};
                    if (req_bad) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (bus.req_write && bus.req_size == SZ_WORD) begin
                        state_d     = S_SETUP;
                        mem_wdata_d = bus.req_wdata;
                    end else begin
                        state_d    = S_RD;
                        mem_read_d = 1'b1;
                    end
                end
            end
            S_RD: begin
                if (write_q) begin
                    state_d     = S_SETUP;
                    mem_wdata_d = store_merge(bus.mem_rdata, wdata_q, size_q, lane_q);
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_extend(bus.mem_rdata, size_q, signed_q, lane_q);
                end
            end
            S_SETUP: begin
                state_d     = S_WR;
                mem_write_d = 1'b1;
            end
            S_WR: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            lane_q       <= 2'b00;
            wdata_q      <= 32'h0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE) && rst_n;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory on the memory port.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    load_store_unit_if bus();

    load_store_unit #(.MEM_WORDS(1024)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [0:1023];
    logic        pre_we = 1'b0;
    logic [9:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (bus.mem_write) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
    end

    assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr[11:2]] : 32'h0;

    // Observations from the last do_req call; mask bit k set = strobe high in cycle T+k.
    int          lat;
    logic [15:0] rd_mask, wr_mask;
    logic [31:0] got_rdata, addr_k1;
    logic        got_err, idle_bad, rdy_after;

    task automatic preload(input logic [9:0] idx, input logic [31:0] data);
        pre_we = 1'b1; pre_idx = idx; pre_data = data;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd);
        lat = 0; rd_mask = '0; wr_mask = '0; got_rdata = '0; got_err = 1'b0; idle_bad = 1'b0;
        addr_k1 = '0;
        bus.req_write = w; bus.req_size = sz; bus.req_signed = sg;
        bus.req_addr = a; bus.req_wdata = wd; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        addr_k1 = bus.mem_addr;
        for (int k = 1; k <= 12; k++) begin
            if (bus.mem_read)  rd_mask[k] = 1'b1;
            if (bus.mem_write) wr_mask[k] = 1'b1;
            if (bus.resp_valid) begin
                lat = k; got_rdata = bus.resp_rdata; got_err = bus.resp_err;
                break;
            end
            if (bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) idle_bad = 1'b1;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        rdy_after = bus.req_ready;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10;
        bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        preload(10'd3, 32'hD000000D);
        preload(10'd4, 32'h0);
        preload(10'd1023, 32'h8000_0000);
        for (int i = 5; i <= 8; i++) preload(10'(i), {4{8'(i * 17)}});
        checks++;
        if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", bus.req_ready); end
        checks++;
        if ({bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write} !== 4'b0 ||
            bus.resp_rdata !== 32'h0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
            errors++; $display("FAIL rst_outputs got nonzero registered output want all 0");
        end
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", bus.req_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_load;
        logic [31:0] t_addr [6] = '{32'h0C, 32'h0F, 32'h0F, 32'h0E, 32'h0C, 32'hFFF};
        logic [1:0]  t_size [6] = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
        logic        t_sgn  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] t_exp  [6] = '{32'hD000000D, 32'hFFFFFFD0, 32'h000000D0,
                                    32'hFFFFD000, 32'h0000000D, 32'h00000080};
        for (int i = 0; i < 6; i++) begin
            do_req(1'b0, t_size[i], t_sgn[i], t_addr[i], 32'hFFFF_FFFF);
            checks++;
            if (got_rdata !== t_exp[i]) begin errors++; $display("FAIL load%0d_rdata got %h want %h", i, got_rdata, t_exp[i]); end
            checks++;
            if (lat !== 2 || got_err !== 1'b0) begin errors++; $display("FAIL load%0d_lat_err got lat=%0d err=%b want lat=2 err=0", i, lat, got_err); end
            checks++;
            if (rd_mask !== 16'h0002 || wr_mask !== 16'h0) begin errors++; $display("FAIL load%0d_strobes got rd=%h wr=%h want rd=0002 wr=0000", i, rd_mask, wr_mask); end
            checks++;
            if (addr_k1 !== {t_addr[i][31:2], 2'b00}) begin errors++; $display("FAIL load%0d_memaddr got %h want %h", i, addr_k1, {t_addr[i][31:2], 2'b00}); end
            checks++;
            if (idle_bad !== 1'b0 || rdy_after !== 1'b1) begin errors++; $display("FAIL load%0d_idle got idle_bad=%b ready=%b want 0 1", i, idle_bad, rdy_after); end
        end
    endtask

    task automatic test_store;
        do_req(1'b1, 2'b00, 1'b0, 32'h0D, 32'h123456AB);
        checks++;
        if (mem[3] !== 32'hD000AB0D) begin errors++; $display("FAIL st_byte_mem got %h want d000ab0d", mem[3]); end
        checks++;
        if (wr_mask !== 16'h0008 || rd_mask !== 16'h0002 || lat !== 4) begin
            errors++; $display("FAIL st_byte_timing got wr=%h rd=%h lat=%0d want wr=0008 rd=0002 lat=4", wr_mask, rd_mask, lat);
        end
        checks++;
        if (got_rdata !== 32'h0 || got_err !== 1'b0) begin errors++; $display("FAIL st_byte_resp got rdata=%h err=%b want 0 0", got_rdata, got_err); end

        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFEF00D);
        checks++;
        if (mem[4] !== 32'hCAFEF00D) begin errors++; $display("FAIL st_word_mem got %h want cafef00d", mem[4]); end
        checks++;
        if (wr_mask !== 16'h0004 || rd_mask !== 16'h0 || lat !== 3) begin
            errors++; $display("FAIL st_word_timing got wr=%h rd=%h lat=%0d want wr=0004 rd=0000 lat=3", wr_mask, rd_mask, lat);
        end

        do_req(1'b1, 2'b01, 1'b0, 32'h0E, 32'h0000BEEF);
        checks++;
        if (mem[3] !== 32'hBEEFAB0D) begin errors++; $display("FAIL st_half_mem got %h want beefab0d", mem[3]); end
        checks++;
        if (wr_mask !== 16'h0008 || lat !== 4 || rdy_after !== 1'b1) begin
            errors++; $display("FAIL st_half_timing got wr=%h lat=%0d ready=%b want wr=0008 lat=4 ready=1", wr_mask, lat, rdy_after);
        end
    endtask

    task automatic test_errors;
        logic        t_w    [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  t_size [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
        logic [31:0] t_addr [4] = '{32'h02, 32'h01, 32'h00, 32'h1000};
        for (int i = 0; i < 4; i++) begin
            do_req(t_w[i], t_size[i], 1'b1, t_addr[i], 32'hFFFF_FFFF);
            checks++;
            if (lat !== 1 || got_err !== 1'b1 || got_rdata !== 32'h0) begin
                errors++; $display("FAIL err%0d_resp got lat=%0d err=%b rdata=%h want lat=1 err=1 rdata=0", i, lat, got_err, got_rdata);
            end
            checks++;
            if (rd_mask !== 16'h0 || wr_mask !== 16'h0) begin errors++; $display("FAIL err%0d_strobes got rd=%h wr=%h want 0 0", i, rd_mask, wr_mask); end
        end
        checks++;
        if (mem[0] !== 32'h0) begin errors++; $display("FAIL err_mem0 got %h want 0", mem[0]); end
    endtask

    task automatic test_abort;
        logic seen;
        bus.req_write = 1'b1; bus.req_size = 2'b00; bus.req_signed = 1'b0;
        bus.req_addr = 32'h0D; bus.req_wdata = 32'h00000077; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        checks++;
        if (bus.mem_read !== 1'b1) begin errors++; $display("FAIL abort_in_rd got mem_read=%b want 1", bus.mem_read); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.mem_read, bus.mem_write} !== 5'b0 ||
            bus.resp_rdata !== 32'h0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
            errors++; $display("FAIL abort_outputs got nonzero output want all 0");
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", bus.req_ready); end
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.mem_write || bus.resp_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL abort_quiet got activity=%b want 0", seen); end
        checks++;
        if (mem[3] !== 32'hBEEFAB0D) begin errors++; $display("FAIL abort_mem got %h want beefab0d", mem[3]); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_d [4] = '{32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
        int n_acc = 0, n_resp = 0, rd_cnt = 0, bad_space = 0, last_resp = -100;
        logic acc;
        bus.req_write = 1'b0; bus.req_size = 2'b10; bus.req_signed = 1'b0;
        bus.req_addr = 32'h14; bus.req_valid = 1'b1;
        for (int c = 0; c < 40 && n_resp < 4; c++) begin
            acc = bus.req_ready && bus.req_valid;
            if (bus.mem_read) rd_cnt++;
            if (bus.resp_valid) begin
                checks++;
                if (bus.resp_rdata !== exp_d[n_resp]) begin
                    errors++; $display("FAIL b2b_rdata%0d got %h want %h", n_resp, bus.resp_rdata, exp_d[n_resp]);
                end
                last_resp = c;
                n_resp++;
            end
            if (acc) begin
                if (n_acc > 0 && c != last_resp + 1) bad_space++;
                n_acc++;
            end
            @(posedge clk); #1;
            if (acc) begin
                if (n_acc == 4) bus.req_valid = 1'b0;
                else bus.req_addr = 32'h14 + 32'(4 * n_acc);
            end
        end
        bus.req_valid = 1'b0;
        checks++;
        if (n_resp !== 4 || n_acc !== 4) begin errors++; $display("FAIL b2b_count got acc=%0d resp=%0d want 4 4", n_acc, n_resp); end
        checks++;
        if (bad_space !== 0) begin errors++; $display("FAIL b2b_spacing got %0d late accepts want 0", bad_space); end
        checks++;
        if (rd_cnt !== 4) begin errors++; $display("FAIL b2b_reads got %0d read cycles want 4", rd_cnt); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_errors();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
